sync_bus_stable_capture: RTL and testbench
==========================================

// Module: sync_bus_stable_capture
// PURPOSE
//  Sits directly downstream of the multi-stage bus synchronizer in the destination domain.
//  Bits of a synchronized bus can settle on different cycles, so the raw synchronized word is
//  not coherent. This block qualifies it: it commits a new word only after the word has been
//  held unchanged for STABLE_CYCLES consecutive clocks. It then pulses upd, and counts the
//  transients it rejects.
// PARAMETERS
//  DATAWTH        8   width of the synchronized bus
//  STABLE_CYCLES  3   consecutive identical samples required to commit; legal range 2..255
//  GLITCH_W       8   width of the saturating glitch counter
// PORTS
//  clk         input   1          destination-domain clock
//  reset       input   1          synchronous, active-high reset
//  sync_in     input   DATAWTH    synchronized bus from the bus synchronizer output
//  glitch_clr  input   1          clears glitch_cnt on this edge
//  data_out    output  DATAWTH    last committed stable word (registered)
//  upd         output  1          one-cycle pulse on the edge where data_out takes a new value
//  busy        output  1          1 while a candidate word is being qualified (state SETTLE)
//  glitch_cnt  output  GLITCH_W   saturating count of abandoned candidates
// BEHAVIOUR
//  Registers
//   - data_out, cand[DATAWTH], cnt[8], state{IDLE,SETTLE}, upd, glitch_cnt.
//   - busy = (state==SETTLE), decoded from the state register.
//  Reset (synchronous, highest priority)
//   - data_out=0, cand=0, cnt=0, state=IDLE, upd=0, glitch_cnt=0.
//   - Takes effect mid-qualification too: the candidate is discarded, no upd, no glitch count.
//  Default: upd=0 every cycle unless a commit occurs.
//  IDLE
//   - sync_in==data_out: hold.
//   - sync_in!=data_out: cand<=sync_in, cnt<=1, state<=SETTLE.
//  SETTLE, sync_in==cand
//   - cnt==STABLE_CYCLES-1: commit. data_out<=cand, upd<=1, cnt<=0, state<=IDLE.
//   - Otherwise cnt<=cnt+1.
//  SETTLE, sync_in!=cand
//   - Glitch: glitch_cnt increments, saturating at all-ones.
//   - sync_in==data_out: state<=IDLE, cnt<=0.
//   - Otherwise restart on the new word: cand<=sync_in, cnt<=1, stay in SETTLE.
//  Latency
//   - A word first sampled at edge T and held commits at edge T+STABLE_CYCLES-1.
//   - data_out and upd are visible after that edge.
//   - data_out never shows a word sampled fewer than STABLE_CYCLES consecutive times.
//  Back-to-back commits
//   - After a commit the FSM is in IDLE and compares against the new data_out.
//   - A different word on the very next edge starts a fresh qualification.
//   - Minimum spacing between upd pulses is STABLE_CYCLES cycles.
//  glitch_clr
//   - glitch_cnt<=0. Clear wins over a glitch on the same edge.
//  Constraints
//   - cnt is compared at full 8-bit width; no wrap is possible within the legal range.
//   - STABLE_CYCLES outside 2..255 stops elaboration with $fatal.
// TESTING (DATAWTH=8, STABLE_CYCLES=3, GLITCH_W=8 unless stated)
//  1 Reset, sync_in=0x00 -> data_out=0x00, upd=0, busy=0, glitch_cnt=0 on first post-reset cycle.
//  2 sync_in 0x00->0xA5 held at edge T -> busy=1 after T, T+1; upd=1 and data_out=0xA5 after T+2 only.
//  3 sync_in=0xA5 for one edge, then 0x00 -> no upd, data_out stays 0x00, glitch_cnt=1, busy=0.
//  4 sync_in 0x11 for one edge, then 0x22 held -> glitch_cnt=1; data_out=0x22 two edges after the 0x22 restart.
//  5 GLITCH_W=2, five glitches -> glitch_cnt saturates at 3; glitch_clr on a glitch edge -> glitch_cnt=0.
//  6 sync_in=0x5A for 2 edges, reset for 1 edge, 0x5A held -> data_out=0, no upd; commit 3 edges after reset release.

Source files
------------

// File: rtl/sync_bus_stable_capture.sv
// sync_bus_stable_capture: commits a synchronized bus word only after it has
// been held unchanged for STABLE_CYCLES clocks, and counts rejected transients.
//
// Ports:
//   clk         destination-domain clock
//   reset       synchronous, active-high reset
//   sync_in     raw synchronized bus (bits may settle on different cycles)
//   glitch_clr  clears glitch_cnt (wins over a glitch on the same edge)
//   data_out    last committed stable word
//   upd         one-cycle pulse on the edge data_out takes a new value
//   busy        high while a candidate word is being qualified
//   glitch_cnt  saturating count of abandoned candidates
module sync_bus_stable_capture #(
  parameter int DATAWTH       = 8,
  parameter int STABLE_CYCLES = 3,
  parameter int GLITCH_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATAWTH-1:0] sync_in,
  input  logic               glitch_clr,
  output logic [DATAWTH-1:0] data_out,
  output logic               upd,
  output logic               busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_cfg
    $fatal(1, "STABLE_CYCLES must be in 2..255");
  end

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  // Count value at which the candidate has been seen STABLE_CYCLES times.
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  localparam logic [GLITCH_W-1:0] G_MAX = '1;
  localparam logic [GLITCH_W-1:0] G_ONE = GLITCH_W'(1);

  state_t               state_q;
  state_t               state_d;
  logic [DATAWTH-1:0]   cand_q;
  logic [DATAWTH-1:0]   cand_d;
  logic [7:0]           cnt_q;
  logic [7:0]           cnt_d;
  logic [DATAWTH-1:0]   data_d;
  logic                 upd_d;
  logic [GLITCH_W-1:0]  glitch_d;
  logic                 glitch_hit;

  assign busy = (state_q == SETTLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      data_out   <= '0;
      upd        <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      data_out   <= data_d;
      upd        <= upd_d;
      glitch_cnt <= glitch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    data_d     = data_out;
    upd_d      = 1'b0;
    glitch_d   = glitch_cnt;
    glitch_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync_in != data_out) begin
          cand_d  = sync_in;
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync_in == cand_q) begin
          if (cnt_q == LAST) begin
            data_d  = cand_q;
            upd_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          glitch_hit = 1'b1;
          // Falling back to the committed word ends
          // qualification; anything else restarts it.
          if (sync_in == data_out) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cand_d = sync_in;
            cnt_d  = 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_hit && glitch_cnt != G_MAX) begin
      glitch_d = glitch_cnt + G_ONE;
    end
  end

endmodule

// File: tb/tb_sync_bus_stable_capture.sv
// tb_sync_bus_stable_capture: table vectors, corner sequences and
// randomized traffic against a queue-based model of the capture rules.
module tb_sync_bus_stable_capture;

  localparam int SC = 3;

  logic       clk;
  logic       reset;
  logic [7:0] sync_in;
  logic       glitch_clr;
  logic [7:0] data_out;
  logic       upd;
  logic       busy;
  logic [7:0] glitch_cnt;
  logic [7:0] data_out2;
  logic       upd2;
  logic       busy2;
  logic [1:0] glitch_cnt2;

  int nvec;
  int nerr;

  sync_bus_stable_capture #(
    .DATAWTH(8), .STABLE_CYCLES(SC), .GLITCH_W(8)
  ) dut (
    .clk(clk), .reset(reset), .sync_in(sync_in),
    .glitch_clr(glitch_clr), .data_out(data_out),
    .upd(upd), .busy(busy), .glitch_cnt(glitch_cnt)
  );

  sync_bus_stable_capture #(
    .DATAWTH(8), .STABLE_CYCLES(SC), .GLITCH_W(2)
  ) dut2 (
    .clk(clk), .reset(reset), .sync_in(sync_in),
    .glitch_clr(glitch_clr), .data_out(data_out2),
    .upd(upd2), .busy(busy2), .glitch_cnt(glitch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: q holds the run of identical samples that differ from
  // the committed word; a full run of SC samples commits.
  logic [7:0] m_data;
  logic       m_upd;
  int         m_glitch;
  int         m_glitch2;
  logic [7:0] q[$];

  task automatic model(input logic r, input logic [7:0] s,
                       input logic c);
    logic g;
    g = 1'b0;
    if (r) begin
      m_data = 8'h00; m_upd = 1'b0;
      m_glitch = 0; m_glitch2 = 0;
      q.delete();
    end else begin
      m_upd = 1'b0;
      if (q.size() > 0 && s != q[$]) begin
        g = 1'b1;
        q.delete();
      end
      if (s != m_data) q.push_back(s);
      if (q.size() == SC) begin
        m_data = s;
        m_upd = 1'b1;
        q.delete();
      end
      if (c) begin
        m_glitch = 0; m_glitch2 = 0;
      end else if (g) begin
        if (m_glitch < 255) m_glitch++;
        if (m_glitch2 < 3) m_glitch2++;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] s,
                      input logic c);
    reset = r; sync_in = s; glitch_clr = c;
    @(posedge clk);
    model(r, s, c);
    #1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_model(input string nm, input int idx);
    chk({nm, ".data"}, idx, data_out, m_data);
    chk({nm, ".upd"}, idx, 8'(upd), 8'(m_upd));
    chk({nm, ".busy"}, idx, 8'(busy), 8'(q.size() > 0));
    chk({nm, ".glitch"}, idx, glitch_cnt, 8'(m_glitch));
  endtask

  typedef struct {
    logic       r;
    logic [7:0] s;
    logic       c;
    logic [7:0] d;
    logic       u;
    logic       b;
    logic [7:0] g;
  } vec_t;

  vec_t tbl[26];

  initial begin
    nvec = 0; nerr = 0;
    reset = 1'b1; sync_in = 8'h00; glitch_clr = 1'b0;

    tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 8'd2};
    tbl[11] = '{1'b0, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 8'd2};
    tbl[12] = '{1'b0, 8'h22, 1'b0, 8'h22, 1'b1, 1'b0, 8'd2};
    tbl[13] = '{1'b0, 8'h33, 1'b0, 8'h22, 1'b0, 1'b1, 8'd2};
    tbl[14] = '{1'b0, 8'h44, 1'b1, 8'h22, 1'b0, 1'b1, 8'd0};
    tbl[15] = '{1'b0, 8'h44, 1'b0, 8'h22, 1'b0, 1'b1, 8'd0};
    tbl[16] = '{1'b0, 8'h44, 1'b0, 8'h44, 1'b1, 1'b0, 8'd0};
    tbl[17] = '{1'b0, 8'h55, 1'b0, 8'h44, 1'b0, 1'b1, 8'd0};
    tbl[18] = '{1'b0, 8'h55, 1'b0, 8'h44, 1'b0, 1'b1, 8'd0};
    tbl[19] = '{1'b0, 8'h55, 1'b0, 8'h55, 1'b1, 1'b0, 8'd0};
    tbl[20] = '{1'b0, 8'h5A, 1'b0, 8'h55, 1'b0, 1'b1, 8'd0};
    tbl[21] = '{1'b0, 8'h5A, 1'b0, 8'h55, 1'b0, 1'b1, 8'd0};
    tbl[22] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[23] = '{1'b0, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[24] = '{1'b0, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[25] = '{1'b0, 8'h5A, 1'b0, 8'h5A, 1'b1, 1'b0, 8'd0};

    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].c);
      chk("tbl.data", i, data_out, tbl[i].d);
      chk("tbl.upd", i, 8'(upd), 8'(tbl[i].u));
      chk("tbl.busy", i, 8'(busy), 8'(tbl[i].b));
      chk("tbl.glitch", i, glitch_cnt, tbl[i].g);
    end

    // Narrow counter saturation, then clear on a glitch edge.
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h11, 1'b0);
      step(1'b0, 8'h00, 1'b0);
    end
    chk("sat.g2", 0, 8'(glitch_cnt2), 8'd3);
    chk("sat.g8", 0, glitch_cnt, 8'd5);
    chk("sat.data", 0, data_out2, 8'h00);
    step(1'b0, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("clr.g2", 0, 8'(glitch_cnt2), 8'd0);
    chk("clr.g8", 0, glitch_cnt, 8'd0);

    // Randomized traffic biased toward holding so commits occur.
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 600; i++) begin
      logic [7:0] s;
      logic r;
      logic c;
      int k;
      s = sync_in;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 4);
        case (k)
          0: s = 8'h00;
          1: s = 8'hA5;
          2: s = 8'h5A;
          3: s = 8'hFF;
          default: s = 8'($urandom);
        endcase
      end
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 31) == 0);
      step(r, s, c);
      chk_model("rnd", i);
      chk("rnd.g2", i, 8'(glitch_cnt2), 8'(m_glitch2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
